// File: rtl/image_bram_writer.sv
// Image BRAM writer: buffers incoming 8-bit pixels in a small skid FIFO and writes
// one pixel per BRAM word, then hands the completed image to a reader via start/image_done.
module image_bram_writer #(
  parameter int unsigned IMG_PIXELS = 784,
  parameter logic [31:0] BASE_ADDR  = '0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HOLD_LEVEL = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pixel_i,
  input  logic        pixel_valid,
  output logic        interrupt,
  output logic        start,
  input  logic        image_done,
  output logic [31:0] bram_address,
  output logic [31:0] bram_wdata,
  output logic        bram_we,
  output logic [15:0] pixel_count,
  output logic        overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD_LEVEL);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [15:0]      IMG_C    = 16'(IMG_PIXELS);

  typedef enum logic {FILL, FULL} state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      pixel_count_q, pixel_count_d;
  logic [31:0]      bram_address_q, bram_address_d;
  logic [31:0]      bram_wdata_q, bram_wdata_d;
  logic             bram_we_q, bram_we_d;
  logic             start_q, start_d;
  logic             overflow_q, overflow_d;

  logic fifo_full, fifo_empty, push, can_write, bypass, pop, fifo_wr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d        = state_q;
    mem_d          = mem_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    cnt_d          = cnt_q;
    pixel_count_d  = pixel_count_q;
    bram_address_d = bram_address_q;
    bram_wdata_d   = bram_wdata_q;
    bram_we_d      = 1'b0;
    start_d        = 1'b0;
    overflow_d     = overflow_q;

    fifo_full  = (cnt_q == DEPTH_C);
    fifo_empty = (cnt_q == '0);
    push       = pixel_valid && !fifo_full;
    if (pixel_valid && fifo_full) overflow_d = 1'b1;

    // An empty FIFO lets the incoming pixel go straight to BRAM so it lands one cycle later;
    // the count guard blocks a second write during the cycle that hands over to FULL.
    can_write = (state_q == FILL) && (pixel_count_q != IMG_C);
    bypass    = can_write && fifo_empty && pixel_valid;
    pop       = can_write && !fifo_empty;
    fifo_wr   = push && !bypass;

    if (bypass || pop) begin
      bram_we_d      = 1'b1;
      bram_wdata_d   = {24'b0, bypass ? pixel_i : mem_q[rd_ptr_q]};
      bram_address_d = BASE_ADDR + 32'(pixel_count_q);
      pixel_count_d  = pixel_count_q + 16'd1;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (fifo_wr) begin
      mem_d[wr_ptr_q] = pixel_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    case ({fifo_wr, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      FILL: if (pixel_count_q == IMG_C) begin
        state_d = FULL;
        start_d = 1'b1;
      end
      FULL: if (image_done) begin
        state_d       = FILL;
        pixel_count_d = '0;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= FILL;
      mem_q          <= '{default: '0};
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      cnt_q          <= '0;
      pixel_count_q  <= '0;
      bram_address_q <= BASE_ADDR;
      bram_wdata_q   <= '0;
      bram_we_q      <= 1'b0;
      start_q        <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_q          <= mem_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      cnt_q          <= cnt_d;
      pixel_count_q  <= pixel_count_d;
      bram_address_q <= bram_address_d;
      bram_wdata_q   <= bram_wdata_d;
      bram_we_q      <= bram_we_d;
      start_q        <= start_d;
      overflow_q     <= overflow_d;
    end
  end

  assign interrupt    = (state_q == FULL) || (cnt_q >= HOLD_C);
  assign start        = start_q;
  assign bram_address = bram_address_q;
  assign bram_wdata   = bram_wdata_q;
  assign bram_we      = bram_we_q;
  assign pixel_count  = pixel_count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_image_bram_writer.sv
// Directed bench for image_bram_writer with a 16-pixel image, 4-entry FIFO, hold level 2.
module tb_image_bram_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  pixel_i = '0;
  logic        pixel_valid = 1'b0;
  logic        image_done = 1'b0;
  logic        interrupt, start, bram_we, overflow;
  logic [31:0] bram_address, bram_wdata;
  logic [15:0] pixel_count;

  int checks = 0;
  int failures = 0;

  image_bram_writer #(
    .IMG_PIXELS(16),
    .BASE_ADDR (32'd0),
    .FIFO_DEPTH(4),
    .HOLD_LEVEL(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_i     (pixel_i),
    .pixel_valid (pixel_valid),
    .interrupt   (interrupt),
    .start       (start),
    .image_done  (image_done),
    .bram_address(bram_address),
    .bram_wdata  (bram_wdata),
    .bram_we     (bram_we),
    .pixel_count (pixel_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  bram_address, 32'd0);
    check({tag, "_wdata"}, bram_wdata, 32'd0);
    check({tag, "_we"},    32'(bram_we), 32'd0);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_ovf"},   32'(overflow), 32'd0);
    check({tag, "_irq"},   32'(interrupt), 32'd0);
    check({tag, "_cnt"},   32'(pixel_count), 32'd0);
  endtask

  task automatic write_one(input string tag, input logic [7:0] px,
                           input logic [31:0] exp_addr, input logic [15:0] exp_cnt);
    pixel_i = px;
    pixel_valid = 1'b1;
    step();
    check({tag, "_we"},    32'(bram_we), 32'd1);
    check({tag, "_addr"},  bram_address, exp_addr);
    check({tag, "_wdata"}, bram_wdata, {24'd0, px});
    check({tag, "_cnt"},   32'(pixel_count), 32'(exp_cnt));
    check({tag, "_start"}, 32'(start), 32'd0);
  endtask

  initial begin
    repeat (3) step();
    check_reset_vals("rst");
    reset = 1'b1;
    step();

    // single pixel into an idle block
    pixel_i = 8'hA5;
    pixel_valid = 1'b1;
    #1 check("single_irq_pre", 32'(interrupt), 32'd0);
    step();
    pixel_valid = 1'b0;
    check("single_we",    32'(bram_we), 32'd1);
    check("single_wdata", bram_wdata, 32'h0000_00A5);
    check("single_addr",  bram_address, 32'd0);
    check("single_irq",   32'(interrupt), 32'd0);
    check("single_cnt",   32'(pixel_count), 32'd1);
    step();
    check("idle_we",   32'(bram_we), 32'd0);
    check("idle_addr", bram_address, 32'd0);

    // image_done while filling is ignored
    image_done = 1'b1;
    step();
    image_done = 1'b0;
    check("fill_done_start", 32'(start), 32'd0);
    check("fill_done_cnt",   32'(pixel_count), 32'd1);
    check("fill_done_irq",   32'(interrupt), 32'd0);
    step();
    check("fill_done_start2", 32'(start), 32'd0);

    for (int i = 1; i < 7; i++)
      write_one("pre_rst", 8'(8'h30 + i), 32'(i), 16'(i + 1));
    pixel_valid = 1'b0;

    // asynchronous reset after 7 writes
    reset = 1'b0;
    #1 check_reset_vals("midrst");
    step();
    check_reset_vals("midrst_hold");
    reset = 1'b1;
    step();
    write_one("post_rst", 8'h42, 32'd0, 16'd1);
    pixel_valid = 1'b0;

    reset = 1'b0;
    step();
    reset = 1'b1;
    step();

    // full image of 16 back-to-back pixels
    for (int i = 0; i < 16; i++)
      write_one("img", 8'(8'h10 + i), 32'(i), 16'(i + 1));
    pixel_valid = 1'b0;
    step();
    check("full_start", 32'(start), 32'd1);
    check("full_we",    32'(bram_we), 32'd0);
    check("full_cnt",   32'(pixel_count), 32'd16);
    check("full_irq",   32'(interrupt), 32'd1);
    step();
    check("full_start_pulse", 32'(start), 32'd0);

    // three pixels queued while FULL, released by image_done
    for (int k = 0; k < 3; k++) begin
      pixel_i = 8'(8'h61 + k);
      pixel_valid = 1'b1;
      step();
      check("q3_we",  32'(bram_we), 32'd0);
      check("q3_irq", 32'(interrupt), 32'd1);
    end
    pixel_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("q3_wait_we",  32'(bram_we), 32'd0);
      check("q3_wait_irq", 32'(interrupt), 32'd1);
      check("q3_wait_cnt", 32'(pixel_count), 32'd16);
    end
    image_done = 1'b1;
    step();
    image_done = 1'b0;
    check("q3_rel_cnt", 32'(pixel_count), 32'd0);
    check("q3_rel_we",  32'(bram_we), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("q3_drain_we",    32'(bram_we), 32'd1);
      check("q3_drain_addr",  bram_address, 32'(k));
      check("q3_drain_wdata", bram_wdata, 32'(8'h61 + k));
    end
    step();
    check("q3_end_we",  32'(bram_we), 32'd0);
    check("q3_end_irq", 32'(interrupt), 32'd0);
    check("q3_end_cnt", 32'(pixel_count), 32'd3);
    check("q3_end_ovf", 32'(overflow), 32'd0);

    for (int j = 0; j < 13; j++)
      write_one("img2", 8'(8'h70 + j), 32'(j + 3), 16'(j + 4));
    pixel_valid = 1'b0;
    step();
    check("img2_start", 32'(start), 32'd1);

    // five pixels while FULL: the fifth overflows the 4-entry FIFO
    for (int k = 0; k < 5; k++) begin
      pixel_i = 8'(8'h81 + k);
      pixel_valid = 1'b1;
      step();
      check("ovf_we",  32'(bram_we), 32'd0);
      check("ovf_flag", 32'(overflow), (k == 4) ? 32'd1 : 32'd0);
    end
    pixel_valid = 1'b0;
    step();
    check("ovf_sticky", 32'(overflow), 32'd1);
    image_done = 1'b1;
    step();
    image_done = 1'b0;
    check("ovf_rel_cnt", 32'(pixel_count), 32'd0);
    check("ovf_rel_ovf", 32'(overflow), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("ovf_drain_we",    32'(bram_we), 32'd1);
      check("ovf_drain_addr",  bram_address, 32'(k));
      check("ovf_drain_wdata", bram_wdata, 32'(8'h81 + k));
    end
    step();
    check("ovf_end_we",  32'(bram_we), 32'd0);
    check("ovf_end_cnt", 32'(pixel_count), 32'd4);
    check("ovf_end_ovf", 32'(overflow), 32'd1);
    check("ovf_end_irq", 32'(interrupt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
